// File: rtl/aer_addr_rx.sv
// aer_addr_rx: 4-phase AER receiver that synchronizes req, latches the address and emits a one-cycle ae strobe.
// It also keeps a saturating event count and a sticky handshake-timeout flag.
module aer_addr_rx #(
    parameter int bit_addr    = 9,
    parameter int sync_stages = 2,
    parameter int ack_hold    = 2,
    parameter int timeout     = 255
) (
    input  logic                clk_i,
    input  logic                clr_i,
    input  logic                aer_req_i,
    input  logic [bit_addr-1:0] aer_addr_i,
    output logic                aer_ack_o,
    input  logic                en_i,
    input  logic                err_clr_i,
    output logic [bit_addr-1:0] addr_o,
    output logic                ae_o,
    output logic [15:0]         ev_cnt_o,
    output logic                timeout_err_o
);
    typedef enum logic [1:0] {FLUSH, IDLE, LATCH, ACK} state_t;
    state_t state_q, state_d;
    logic [sync_stages-1:0] sync_q;
    logic [7:0] cnt_q, cnt_d;
    logic [bit_addr-1:0] addr_q, addr_d;
    logic [15:0] ev_cnt_q, ev_cnt_d;
    logic ae_q, ack_q, err_q, err_d, abort;
    logic req_s;

    assign req_s = sync_q[sync_stages-1];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ev_cnt_d = ev_cnt_q;
        abort    = 1'b0;
        case (state_q)
            // Require a clean run of low req before arming, so a stale request is never counted.
            FLUSH: begin
                if (req_s) cnt_d = 8'd0;
                else if (cnt_q == 8'(sync_stages + 1)) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else cnt_d = cnt_q + 8'd1;
            end
            IDLE: if (en_i && req_s) state_d = LATCH;
            LATCH: begin
                addr_d   = aer_addr_i;
                ev_cnt_d = (&ev_cnt_q) ? ev_cnt_q : ev_cnt_q + 16'd1;
                cnt_d    = 8'd0;
                state_d  = ACK;
            end
            ACK: begin
                if (!req_s && cnt_q >= 8'(ack_hold - 1)) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                end else if (req_s && cnt_q == 8'(timeout - 1)) begin
                    state_d = FLUSH;
                    cnt_d   = 8'd0;
                    abort   = 1'b1;
                end else cnt_d = cnt_q + 8'd1;
            end
            default: state_d = FLUSH;
        endcase
        err_d = abort | (err_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or posedge clr_i) begin
        if (clr_i) begin
            state_q  <= FLUSH;
            sync_q   <= '0;
            cnt_q    <= 8'd0;
            addr_q   <= '0;
            ev_cnt_q <= 16'd0;
            ae_q     <= 1'b0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            sync_q   <= {sync_q[sync_stages-2:0], aer_req_i};
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            ev_cnt_q <= ev_cnt_d;
            ae_q     <= (state_q == LATCH);
            ack_q    <= (state_d == ACK);
            err_q    <= err_d;
        end
    end

    assign aer_ack_o     = ack_q;
    assign addr_o        = addr_q;
    assign ae_o          = ae_q;
    assign ev_cnt_o      = ev_cnt_q;
    assign timeout_err_o = err_q;
endmodule
